// File: rtl/i2c_rx_pkg.sv
// Shared definitions for the oversampled I2C write-only frame receiver:
// FSM state encodings, SDA drive constants and the FIFO occupancy width helper.
package i2c_rx_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_DATA_ACK = 3'd4;
    localparam logic [2:0] ST_IGNORE   = 3'd5;

    // Values of sda_oe for acknowledging (pull low) and not acknowledging (release)
    localparam logic OE_ACK  = 1'b1;
    localparam logic OE_NACK = 1'b0;

    // Bits needed to hold an occupancy count of 0..depth inclusive
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_frame_fifo.sv
// Single-clock frame FIFO with first-word-fall-through head, valid/ready pop
// and a registered occupancy count. Pushes while full and pops while empty
// are ignored.
module sync_frame_fifo
    import i2c_rx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          srst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head_data,
    output logic                          valid,
    output logic [lvl_width(DEPTH)-1:0]   level,
    output logic                          full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_width(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    count_r;
    logic [LW-1:0]    count_next_s;
    logic             valid_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == LW'(DEPTH));
    assign level     = count_r;
    assign valid     = valid_r;
    assign head_data = mem_r[rd_ptr_r];

    // Qualify push/pop against full/empty and compute the next occupancy
    always_comb begin
        do_push_s    = push && (count_r != LW'(DEPTH));
        do_pop_s     = pop && (count_r != {LW{1'b0}});
        count_next_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + LW'(1);
            2'b01:   count_next_s = count_r - LW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage array; contents need no reset because valid gates the head
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and registered valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
            valid_r  <= 1'b0;
        end else if (srst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != {LW{1'b0}});
        end
    end

endmodule

// File: rtl/i2c_slave_frame_rx.sv
// Write-only I2C slave receiver, fully synchronous to CLK with SCL/SDA
// oversampled. Matches SLAVE_ADDR, ACKs bytes, assembles FRAME_BYTES-byte
// frames (first byte in the MSBs) and queues them in a FIFO_DEPTH FIFO.
// Optional feature macro: I2C_GEN_CALL_EN -- also accept the general call
// address 7'h00 (write) and tag each queued frame with a gen_call bit.
module i2c_slave_frame_rx
    import i2c_rx_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         FRAME_BYTES = 4,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              scl_in,
    input  logic                              sda_in,
    output logic                              sda_oe,
    output logic [FRAME_BYTES*8-1:0]          frame_data,
    output logic                              frame_valid,
    input  logic                              frame_ready,
    output logic [lvl_width(FIFO_DEPTH)-1:0]  fifo_level,
    output logic                              busy,
    output logic                              ovf_pulse,
    output logic                              partial_pulse,
    output logic [2:0]                        state_out
`ifdef I2C_GEN_CALL_EN
    ,
    output logic                              gen_call
`endif
);

    localparam int         FRAME_W     = FRAME_BYTES * 8;
    localparam logic [3:0] LAST_BYTE_C = 4'(FRAME_BYTES - 1);
`ifdef I2C_GEN_CALL_EN
    localparam int         ENTRY_W     = FRAME_W + 1;
`else
    localparam int         ENTRY_W     = FRAME_W;
`endif

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_prev_r;
    logic                   sda_prev_r;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise_s;
    logic                   scl_fall_s;
    logic                   start_s;
    logic                   stop_s;

    logic [2:0]             state_r;
    logic [2:0]             bit_cnt_r;
    logic [3:0]             byte_cnt_r;
    logic [6:0]             shift_r;
    logic                   ack_phase_r;
    logic [FRAME_W-1:0]     frame_r;
    logic [FRAME_W-1:0]     frame_next_s;
    logic [7:0]             byte_s;
    logic                   addr_hit_s;
    logic                   push_r;
    logic                   fifo_full_s;
    logic [ENTRY_W-1:0]     push_data_s;
    logic [ENTRY_W-1:0]     head_s;
`ifdef I2C_GEN_CALL_EN
    logic                   gen_call_r;
`endif

    assign scl_s      = scl_sync_r[SYNC_STAGES-1];
    assign sda_s      = sda_sync_r[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_prev_r;
    assign scl_fall_s = ~scl_s & scl_prev_r;
    assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
    assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
    assign byte_s     = {shift_r, sda_s};
    assign state_out  = state_r;

    // On the 8th address bit shift_r holds the 7 address bits and sda_s is R/W
`ifdef I2C_GEN_CALL_EN
    assign addr_hit_s = (sda_s == 1'b0) &&
                        ((shift_r == SLAVE_ADDR) || (shift_r == 7'h00));
    assign push_data_s = {gen_call_r, frame_r};
    assign frame_data  = head_s[FRAME_W-1:0];
    assign gen_call    = head_s[FRAME_W];
`else
    assign addr_hit_s  = (sda_s == 1'b0) && (shift_r == SLAVE_ADDR);
    assign push_data_s = frame_r;
    assign frame_data  = head_s;
`endif

    // Pad synchronisers plus one history flop each for edge detection
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
            scl_prev_r <= scl_s;
            sda_prev_r <= sda_s;
        end
    end

    // Merge the just-completed byte into the assembly register at byte_cnt
    always_comb begin
        frame_next_s = frame_r;
        for (int b = 0; b < FRAME_BYTES; b++) begin
            if (byte_cnt_r == 4'(b)) begin
                frame_next_s[(FRAME_BYTES-1-b)*8 +: 8] = byte_s;
            end else begin
                frame_next_s[(FRAME_BYTES-1-b)*8 +: 8] = frame_r[(FRAME_BYTES-1-b)*8 +: 8];
            end
        end
    end

    // Bus protocol FSM: address match, ACK drive, byte assembly and frame push
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= 3'd0;
            byte_cnt_r    <= 4'd0;
            shift_r       <= 7'd0;
            ack_phase_r   <= 1'b0;
            frame_r       <= {FRAME_W{1'b0}};
            sda_oe        <= OE_NACK;
            busy          <= 1'b0;
            ovf_pulse     <= 1'b0;
            partial_pulse <= 1'b0;
            push_r        <= 1'b0;
`ifdef I2C_GEN_CALL_EN
            gen_call_r    <= 1'b0;
`endif
        end else begin
            ovf_pulse     <= 1'b0;
            partial_pulse <= 1'b0;
            push_r        <= 1'b0;
            if (start_s || stop_s) begin
                // A partially assembled frame is discarded on any bus boundary
                if (byte_cnt_r != 4'd0) begin
                    partial_pulse <= 1'b1;
                end
                byte_cnt_r  <= 4'd0;
                bit_cnt_r   <= 3'd0;
                ack_phase_r <= 1'b0;
                sda_oe      <= OE_NACK;
                busy        <= 1'b0;
                state_r     <= start_s ? ST_ADDR : ST_IDLE;
            end else begin
                case (state_r)
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_r   <= {shift_r[5:0], sda_s};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                bit_cnt_r   <= 3'd0;
                                ack_phase_r <= 1'b0;
                                busy        <= addr_hit_s;
                                state_r     <= addr_hit_s ? ST_ADDR_ACK : ST_IGNORE;
`ifdef I2C_GEN_CALL_EN
                                gen_call_r  <= (shift_r == 7'h00);
`endif
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        // Drive from the SCL fall after bit 8 to the following fall
                        if (scl_fall_s) begin
                            if (!ack_phase_r) begin
                                sda_oe      <= OE_ACK;
                                ack_phase_r <= 1'b1;
                            end else begin
                                sda_oe      <= OE_NACK;
                                ack_phase_r <= 1'b0;
                                bit_cnt_r   <= 3'd0;
                                state_r     <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (scl_rise_s) begin
                            shift_r   <= {shift_r[5:0], sda_s};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                bit_cnt_r   <= 3'd0;
                                frame_r     <= frame_next_s;
                                ack_phase_r <= 1'b0;
                                state_r     <= ST_DATA_ACK;
                            end
                        end
                    end
                    ST_DATA_ACK: begin
                        if (scl_fall_s && !ack_phase_r) begin
                            // A frame-completing byte with nowhere to go is NACKed and dropped
                            if (fifo_full_s && (byte_cnt_r == LAST_BYTE_C)) begin
                                ovf_pulse  <= 1'b1;
                                byte_cnt_r <= 4'd0;
                                state_r    <= ST_IGNORE;
                            end else begin
                                sda_oe      <= OE_ACK;
                                ack_phase_r <= 1'b1;
                            end
                        end else if (scl_rise_s && ack_phase_r) begin
                            if (byte_cnt_r == LAST_BYTE_C) begin
                                push_r     <= 1'b1;
                                byte_cnt_r <= 4'd0;
                            end else begin
                                byte_cnt_r <= byte_cnt_r + 4'd1;
                            end
                        end else if (scl_fall_s && ack_phase_r) begin
                            sda_oe      <= OE_NACK;
                            ack_phase_r <= 1'b0;
                            bit_cnt_r   <= 3'd0;
                            state_r     <= ST_DATA;
                        end
                    end
                    ST_IDLE, ST_IGNORE: begin
                        sda_oe <= OE_NACK;
                    end
                    default: begin
                        sda_oe  <= OE_NACK;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    sync_frame_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .srst      (1'b0),
        .push      (push_r),
        .push_data (push_data_s),
        .pop       (frame_ready),
        .head_data (head_s),
        .valid     (frame_valid),
        .level     (fifo_level),
        .full      (fifo_full_s)
    );

endmodule

// File: tb/tb_i2c_slave_frame_rx.sv
// Directed bench for i2c_slave_frame_rx: a bit-banged I2C master on a
// wired-AND SDA, a vector table of single-frame writes, and hand-written
// sequences for overflow, partial frames, streaming pops and mid-transfer reset.
module tb_i2c_slave_frame_rx;

    localparam int H = 10;

    logic        CLK = 1'b0;
    logic        RST;
    logic        scl_m;
    logic        sda_m;
    logic        sda_bus;
    logic        sda_oe;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [2:0]  fifo_level;
    logic        busy;
    logic        ovf_pulse;
    logic        partial_pulse;
    logic [2:0]  state_out;
`ifdef I2C_GEN_CALL_EN
    logic        gen_call;
`endif

    assign sda_bus = sda_m & ~sda_oe;

    always #5 CLK = ~CLK;

    i2c_slave_frame_rx dut (
        .CLK           (CLK),
        .RST           (RST),
        .scl_in        (scl_m),
        .sda_in        (sda_bus),
        .sda_oe        (sda_oe),
        .frame_data    (frame_data),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .fifo_level    (fifo_level),
        .busy          (busy),
        .ovf_pulse     (ovf_pulse),
        .partial_pulse (partial_pulse),
        .state_out     (state_out)
`ifdef I2C_GEN_CALL_EN
        ,
        .gen_call      (gen_call)
`endif
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          ovf_cnt = 0;
    int          part_cnt = 0;
    int          max_lvl = 0;
    logic        oe_seen = 1'b0;
    logic [31:0] popped [$];

    always @(negedge CLK) begin
        if (ovf_pulse) ovf_cnt++;
        if (partial_pulse) part_cnt++;
        if (sda_oe) oe_seen = 1'b1;
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        if (frame_valid && frame_ready) popped.push_back(frame_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(H);
        scl_m = 1'b1; wait_clk(H);
        sda_m = 1'b0; wait_clk(H);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(H);
        scl_m = 1'b1; wait_clk(H);
        sda_m = 1'b1; wait_clk(H);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clk(H);
        scl_m = 1'b1; wait_clk(H);
        scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        sda_m = 1'b1; wait_clk(H);
        scl_m = 1'b1; wait_clk(H/2);
        ack = ~sda_bus;
        wait_clk(H/2);
        scl_m = 1'b0;
    endtask

    // START, address byte and four data bytes; ack bits returned as {addr, b0..b3}
    task automatic send_frame(input logic [7:0] ab, input logic [31:0] d, output logic [4:0] acks);
        logic a;
        i2c_start();
        send_byte(ab, a); acks[4] = a;
        for (int k = 0; k < 4; k++) begin
            send_byte(d[31-8*k -: 8], a);
            acks[3-k] = a;
        end
    endtask

    task automatic pop_one();
        frame_ready = 1'b1; wait_clk(1);
        frame_ready = 1'b0; wait_clk(2);
    endtask

    typedef struct {
        logic [7:0]  addr_b;
        logic [31:0] data;
        logic        exp_ack;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [4:0] acks;
        logic       a;
        vecs[0] = '{8'h84, 32'hDEADBEEF, 1'b1};
        vecs[1] = '{8'h86, 32'h01020304, 1'b0};
        vecs[2] = '{8'h85, 32'hAABBCCDD, 1'b0};
`ifdef I2C_GEN_CALL_EN
        vecs[3] = '{8'h00, 32'h5A5AA5A5, 1'b1};
`else
        vecs[3] = '{8'h00, 32'h5A5AA5A5, 1'b0};
`endif
        vecs[4] = '{8'h84, 32'h01234567, 1'b1};
        vecs[5] = '{8'h04, 32'h99887766, 1'b0};

        RST = 1'b0; scl_m = 1'b1; sda_m = 1'b1; frame_ready = 1'b0;
        wait_clk(5);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state_out, 0);
        check("rst_pulses", {ovf_pulse, partial_pulse}, 0);
        RST = 1'b1;
        wait_clk(5);

        // Table of single-frame writes
        for (int v = 0; v < 6; v++) begin
            oe_seen = 1'b0;
            i2c_start();
            send_byte(vecs[v].addr_b, a);
            check($sformatf("v%0d_addr_ack", v), a, vecs[v].exp_ack);
            check($sformatf("v%0d_busy", v), busy, vecs[v].exp_ack);
            acks = 5'd0;
            for (int k = 0; k < 4; k++) begin
                send_byte(vecs[v].data[31-8*k -: 8], a);
                acks[3-k] = a;
            end
            check($sformatf("v%0d_data_acks", v), acks[3:0], vecs[v].exp_ack ? 4'hF : 4'h0);
            if (!vecs[v].exp_ack) check($sformatf("v%0d_state_ignore", v), state_out, 5);
            i2c_stop();
            wait_clk(5);
            check($sformatf("v%0d_state_idle", v), state_out, 0);
            check($sformatf("v%0d_level", v), fifo_level, vecs[v].exp_ack ? 1 : 0);
            if (vecs[v].exp_ack) begin
                check($sformatf("v%0d_valid", v), frame_valid, 1);
                check($sformatf("v%0d_data", v), frame_data, vecs[v].data);
                pop_one();
                check($sformatf("v%0d_level_pop", v), fifo_level, 0);
            end else begin
                check($sformatf("v%0d_oe_never", v), oe_seen, 0);
            end
        end

        // Overflow: fill the FIFO, then the 5th frame's last byte is NACKed
        for (int f = 0; f < 4; f++) begin
            send_frame(8'h84, 32'h11223300 + 32'(f), acks);
            i2c_stop();
        end
        wait_clk(5);
        check("ovf_level_full", fifo_level, 4);
        ovf_cnt = 0;
        send_frame(8'h84, 32'hCAFED00D, acks);
        check("ovf_acks", acks, 5'b11110);
        i2c_stop();
        wait_clk(5);
        check("ovf_pulse_cnt", ovf_cnt, 1);
        check("ovf_level", fifo_level, 4);
        check("ovf_head", frame_data, 32'h11223300);
        for (int f = 0; f < 4; f++) begin
            check($sformatf("ovf_drain%0d", f), frame_data, 32'h11223300 + 32'(f));
            pop_one();
        end
        check("ovf_drained", fifo_level, 0);

        // Partial frame cut by repeated START
        part_cnt = 0;
        i2c_start();
        send_byte(8'h84, a);
        send_byte(8'h11, a);
        send_byte(8'h22, a);
        send_frame(8'h84, 32'hAABBCCDD, acks);
        i2c_stop();
        wait_clk(5);
        check("part_pulse_cnt", part_cnt, 1);
        check("part_level", fifo_level, 1);
        check("part_data", frame_data, 32'hAABBCCDD);
        pop_one();

        // Back-to-back frames in one transaction with the consumer always ready
        popped.delete();
        max_lvl = 0;
        frame_ready = 1'b1;
        i2c_start();
        send_byte(8'h84, a);
        for (int k = 1; k <= 8; k++) send_byte(8'(k), a);
        i2c_stop();
        wait_clk(5);
        frame_ready = 1'b0;
        check("stream_count", popped.size(), 2);
        if (popped.size() == 2) begin
            check("stream_f0", popped[0], 32'h01020304);
            check("stream_f1", popped[1], 32'h05060708);
        end
        check("stream_max_lvl", max_lvl, 1);

        // Reset in the middle of the 2nd data byte's ACK
        send_frame(8'h84, 32'h0BADF00D, acks);
        i2c_stop();
        wait_clk(5);
        check("prerst_level", fifo_level, 1);
        i2c_start();
        send_byte(8'h84, a);
        send_byte(8'hDE, a);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hAD >> i));
        sda_m = 1'b1;
        for (int k = 0; k < 20 && !sda_oe; k++) wait_clk(1);
        check("prerst_oe", sda_oe, 1);
        #1 RST = 1'b0;
        #1;
        check("rst_mid_oe", sda_oe, 0);
        check("rst_mid_state", state_out, 0);
        check("rst_mid_level", fifo_level, 0);
        wait_clk(3);
        scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(5);
        RST = 1'b1;
        wait_clk(5);
        send_frame(8'h84, 32'hCAFEBABE, acks);
        i2c_stop();
        wait_clk(5);
        check("post_rst_acks", acks, 5'b11111);
        check("post_rst_level", fifo_level, 1);
        check("post_rst_data", frame_data, 32'hCAFEBABE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
